// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Port encodings double as the address-mux select value
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Memory latency limits; the 4-bit counter caps the upper bound
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 15;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_sel, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_sel, mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker: on a conflict the port not served last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_served,
    output logic valid,
    output logic winner
);

    // Single requester wins outright; a conflict goes to the other port
    always_comb begin
        valid  = if_req | d_req;
        winner = PORT_IF;
        if (if_req && d_req) begin
            winner = ~last_served;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data
// accesses, sequencing each access through a fixed-latency memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2
)(
    input  logic clk,
    input  logic reset_n,
    mem_port_arbiter_if.slave bus
);

    // Out-of-range latencies are clamped so the 4-bit counter stays valid
    localparam int LAT = (MEM_LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN :
                         (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX :
                         MEM_LATENCY;
    localparam cnt_t CNT_LOAD = cnt_t'(LAT - 1);

    state_t      state;
    state_t      state_nxt;
    cnt_t        cnt;
    logic        last_served;
    logic        pick_valid;
    logic        pick_winner;
    logic        grant;
    logic        capture;

    logic        if_gnt_q;
    logic        d_gnt_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic        mem_sel_q;
    logic        mem_we_q;
    logic        acc_we;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    mem_arb_pick u_pick (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .last_served (last_served),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arbitrate in IDLE/RESP, leave ACCESS when the count expires
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (pick_valid) begin
                    state_nxt = ACCESS;
                    grant     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access registers, latency counter, pulses and per-port read data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_sel_q   <= PORT_IF;
            mem_we_q    <= 1'b0;
            acc_we      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            cnt         <= '0;
            last_served <= PORT_D;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            if (grant) begin
                mem_sel_q   <= pick_winner;
                cnt         <= CNT_LOAD;
                last_served <= pick_winner;
                if (pick_winner == PORT_D) begin
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                    acc_we      <= bus.d_we;
                    mem_we_q    <= bus.d_we;
                    d_gnt_q     <= 1'b1;
                end else begin
                    mem_addr_q  <= bus.if_addr;
                    acc_we      <= 1'b0;
                    if_gnt_q    <= 1'b1;
                end
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - cnt_t'(1);
            end
            if (capture) begin
                if (mem_sel_q == PORT_D) begin
                    d_rvalid_q <= 1'b1;
                    if (!acc_we) begin
                        d_rdata_q <= bus.mem_rdata;
                    end
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    // Write enable drops in the same cycle reset is asserted
    assign bus.mem_we    = mem_we_q & reset_n;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grant and
// response events, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_rv;
        bit          port;
        logic [31:0] data;
        bit          we;
        int          cyc;
    } ev_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    int   t;
    ev_t  q2[$];
    ev_t  q1[$];

    mem_port_arbiter_if bus2 ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Memory contents with hand-chosen words at the addresses used below
    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        case (addr)
            32'h0000_0040: return 32'h8C01_0004;
            32'h0000_0044: return 32'h8C02_0008;
            32'h0000_0100: return 32'h1111_2222;
            32'h0000_0200: return 32'hCAFE_0001;
            32'h0000_0204: return 32'hCAFE_0002;
            default:       return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign bus2.mem_rdata = mem_model(bus2.mem_addr);
    assign bus1.mem_rdata = mem_model(bus1.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: the value seen at a negedge names the current cycle
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_ev(input int d, input bit is_rv, input bit port,
                           input logic [31:0] data, input bit we, input int c);
        ev_t e;
        e.is_rv = is_rv;
        e.port  = port;
        e.data  = data;
        e.we    = we;
        e.cyc   = c;
        if (d == 0) q2.push_back(e);
        else        q1.push_back(e);
    endtask

    // Compare one DUT's pulses this cycle against the head of its queue
    task automatic observe(input int d, input logic ig, input logic dg, input logic irv,
                           input logic drv, input logic ms, input logic mwe,
                           input logic [31:0] ma, input logic [31:0] ird, input logic [31:0] drd);
        ev_t e;
        bit  empty;
        empty = (d == 0) ? (q2.size() == 0) : (q1.size() == 0);
        if (ig | dg | irv | drv) begin
            if (empty) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut%0d unexpected event: got gnt=%b%b rvalid=%b%b, expected none (cycle %0d)",
                         d, ig, dg, irv, drv, cyc);
            end else begin
                if (d == 0) e = q2.pop_front();
                else        e = q1.pop_front();
                check_output($sformatf("dut%0d event cycle", d), 32'(cyc), 32'(e.cyc));
                check_output($sformatf("dut%0d event kind", d), {31'd0, irv | drv}, {31'd0, e.is_rv});
                check_output($sformatf("dut%0d event port", d), {31'd0, dg | drv}, {31'd0, e.port});
                if (!e.is_rv) begin
                    check_output($sformatf("dut%0d mem_sel", d), {31'd0, ms}, {31'd0, e.port});
                    check_output($sformatf("dut%0d mem_addr", d), ma, e.data);
                    check_output($sformatf("dut%0d mem_we", d), {31'd0, mwe}, {31'd0, e.we});
                end else begin
                    check_output($sformatf("dut%0d rdata", d), e.port ? drd : ird, e.data);
                end
            end
        end else begin
            if (mwe) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut%0d mem_we: got 1 outside grant cycle, expected 0 (cycle %0d)", d, cyc);
            end
            if (!empty) begin
                if (d == 0) e = q2[0];
                else        e = q1[0];
                if (e.cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dut%0d missing event: got none, expected kind=%0d port=%0d at cycle %0d",
                             d, e.is_rv, e.port, e.cyc);
                    if (d == 0) void'(q2.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    // Monitor both DUTs every cycle away from the active edge
    always @(negedge clk) begin
        observe(0, bus2.if_gnt, bus2.d_gnt, bus2.if_rvalid, bus2.d_rvalid,
                bus2.mem_sel, bus2.mem_we, bus2.mem_addr, bus2.if_rdata, bus2.d_rdata);
        observe(1, bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid,
                bus1.mem_sel, bus1.mem_we, bus1.mem_addr, bus1.if_rdata, bus1.d_rdata);
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, " dut2 ctrl"}, {25'd0, bus2.if_gnt, bus2.if_rvalid, bus2.d_gnt,
                     bus2.d_rvalid, bus2.mem_sel, bus2.mem_we, bus2.busy}, 32'd0);
        check_output({tag, " dut2 mem_addr"}, bus2.mem_addr, 32'd0);
        check_output({tag, " dut2 mem_wdata"}, bus2.mem_wdata, 32'd0);
        check_output({tag, " dut2 if_rdata"}, bus2.if_rdata, 32'd0);
        check_output({tag, " dut2 d_rdata"}, bus2.d_rdata, 32'd0);
        check_output({tag, " dut1 ctrl"}, {25'd0, bus1.if_gnt, bus1.if_rvalid, bus1.d_gnt,
                     bus1.d_rvalid, bus1.mem_sel, bus1.mem_we, bus1.busy}, 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
        bus2.d_addr = '0;   bus2.d_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;   bus1.d_wdata = '0;

        tick(3);
        check_reset_state("reset");
        reset_n = 1'b1;
        tick(1);

        // Fetch only
        $display("[TB] fetch only");
        tick(1); t = cyc;
        bus2.if_req = 1'b1; bus2.if_addr = 32'h40;
        push_ev(0, 0, 0, 32'h40, 0, t + 1);
        push_ev(0, 1, 0, 32'h8C01_0004, 0, t + 3);
        tick(1); bus2.if_req = 1'b0;
        tick(1);
        check_output("fetch mem_addr held", bus2.mem_addr, 32'h40);
        check_output("fetch mem_sel held", {31'd0, bus2.mem_sel}, 32'd0);
        check_output("fetch busy", {31'd0, bus2.busy}, 32'd1);
        tick(2);
        check_output("fetch idle busy", {31'd0, bus2.busy}, 32'd0);
        check_output("fetch rdata hold", bus2.if_rdata, 32'h8C01_0004);

        // Back-to-back loads, second request raised during RESP
        $display("[TB] back-to-back loads");
        t = cyc;
        bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h200;
        push_ev(0, 0, 1, 32'h200, 0, t + 1);
        push_ev(0, 1, 1, 32'hCAFE_0001, 0, t + 3);
        tick(1); bus2.d_req = 1'b0;
        tick(2);
        bus2.d_req = 1'b1; bus2.d_addr = 32'h204;
        push_ev(0, 0, 1, 32'h204, 0, t + 4);
        push_ev(0, 1, 1, 32'hCAFE_0002, 0, t + 6);
        tick(1); bus2.d_req = 1'b0;
        check_output("b2b busy", {31'd0, bus2.busy}, 32'd1);
        tick(3);

        // Store: write enable only in the first ACCESS cycle, d_rdata kept
        $display("[TB] store");
        t = cyc;
        bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_addr = 32'h100; bus2.d_wdata = 32'hDEAD_BEEF;
        push_ev(0, 0, 1, 32'h100, 1, t + 1);
        push_ev(0, 1, 1, 32'hCAFE_0002, 0, t + 3);
        tick(1); bus2.d_req = 1'b0; bus2.d_we = 1'b0;
        check_output("store mem_wdata", bus2.mem_wdata, 32'hDEAD_BEEF);
        tick(1);
        check_output("store mem_we second cycle", {31'd0, bus2.mem_we}, 32'd0);
        check_output("store mem_sel", {31'd0, bus2.mem_sel}, 32'd1);
        tick(2);

        // Conflict from reset: IF first, then alternating every 3 cycles
        $display("[TB] conflict");
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1); t = cyc;
        bus2.if_req = 1'b1; bus2.if_addr = 32'h44;
        bus2.d_req  = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h100;
        push_ev(0, 0, 0, 32'h44,        0, t + 1);
        push_ev(0, 1, 0, 32'h8C02_0008, 0, t + 3);
        push_ev(0, 0, 1, 32'h100,       0, t + 4);
        push_ev(0, 1, 1, 32'h1111_2222, 0, t + 6);
        push_ev(0, 0, 0, 32'h44,        0, t + 7);
        push_ev(0, 1, 0, 32'h8C02_0008, 0, t + 9);
        push_ev(0, 0, 1, 32'h100,       0, t + 10);
        push_ev(0, 1, 1, 32'h1111_2222, 0, t + 12);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check_output($sformatf("conflict busy k=%0d", k), {31'd0, bus2.busy}, 32'd1);
            if (k == 10) begin
                bus2.if_req = 1'b0;
                bus2.d_req  = 1'b0;
            end
        end
        tick(1);
        check_output("conflict end busy", {31'd0, bus2.busy}, 32'd0);

        // Reset in the second ACCESS cycle drops the fetch
        $display("[TB] reset mid-access");
        t = cyc;
        bus2.if_req = 1'b1; bus2.if_addr = 32'h40;
        push_ev(0, 0, 0, 32'h40, 0, t + 1);
        tick(1); bus2.if_req = 1'b0;
        tick(1); reset_n = 1'b0;
        check_output("reset mem_we immediate", {31'd0, bus2.mem_we}, 32'd0);
        tick(1);
        check_reset_state("mid-access reset");
        reset_n = 1'b1;
        tick(1); t = cyc;
        bus2.if_req = 1'b1; bus2.if_addr = 32'h44;
        bus2.d_req  = 1'b1; bus2.d_addr = 32'h204;
        push_ev(0, 0, 0, 32'h44,        0, t + 1);
        push_ev(0, 1, 0, 32'h8C02_0008, 0, t + 3);
        push_ev(0, 0, 1, 32'h204,       0, t + 4);
        push_ev(0, 1, 1, 32'hCAFE_0002, 0, t + 6);
        tick(1); bus2.if_req = 1'b0;
        tick(3); bus2.d_req = 1'b0;
        tick(3);

        // Latency-1 build: single load, then sustained fetches every 2 cycles
        $display("[TB] latency 1");
        t = cyc;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h100;
        push_ev(1, 0, 1, 32'h100,       0, t + 1);
        push_ev(1, 1, 1, 32'h1111_2222, 0, t + 2);
        tick(1); bus1.d_req = 1'b0;
        tick(2); t = cyc;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            push_ev(1, 0, 0, 32'h40,        0, t + 1 + 2 * k);
            push_ev(1, 1, 0, 32'h8C01_0004, 0, t + 2 + 2 * k);
        end
        tick(5); bus1.if_req = 1'b0;
        tick(2);
        check_output("lat1 idle busy", {31'd0, bus1.busy}, 32'd0);

        // Bounded drain of anything still outstanding
        for (int k = 0; k < 20 && (q2.size() != 0 || q1.size() != 0); k++) tick(1);
        check_output("dut2 queue drained", 32'(q2.size()), 32'd0);
        check_output("dut1 queue drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch (IF) and data load/store (D) requesters.
- Drives the select of the existing 2-input 32-bit address mux: 0 = fetch/PC address, 1 = data address.
- Sequences each access through a fixed-latency memory and returns the read data or write acknowledge to the winning requester.
- Sits between the multicycle control unit and the memory.

Parameters:
MEM_LATENCY, 2, cycles from address presentation to mem_rdata valid; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held high until if_gnt
if_addr  in  32  fetch address
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched word
d_req  in  1  data request; held high until d_gnt
d_we  in  1  1 = store, 0 = load; qualified by d_req
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  one-cycle grant pulse to data port
d_rvalid  out  1  one-cycle pulse; load data valid, or store complete
d_rdata  out  32  loaded word
mem_sel  out  1  address-mux select: 0 = IF, 1 = D
mem_addr  out  32  registered access address
mem_we  out  1  memory write enable
mem_wdata  out  32  registered store data
mem_rdata  in  32  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; last_served = D, so IF wins the first conflict.
- States: IDLE, ACCESS, RESP.
- Arbitration happens at a clock edge when state is IDLE or RESP.
  - Single requester: that requester wins.
  - Both requesting: the port not in last_served wins.
  - No request: go to (or stay in) IDLE.
- Grant edge (end of cycle T):
  - Go to ACCESS.
  - Latch mem_sel, mem_addr, mem_wdata (D only) and the access type.
  - Load counter with MEM_LATENCY-1.
  - Update last_served.
  - The winner's gnt is high for cycle T+1 only.
- ACCESS:
  - mem_sel, mem_addr and mem_wdata are held stable.
  - mem_we is high only in the first ACCESS cycle, and only for a store.
  - Counter decrements each cycle.
  - At count 0: capture mem_rdata (loads and fetches only) and go to RESP.
- RESP (cycle T+MEM_LATENCY+1):
  - Winner's rvalid is high for exactly this cycle, with its rdata valid.
  - A store pulses d_rvalid and leaves d_rdata unchanged.
  - Arbitration occurs at the end of RESP, so the peak rate is one access per MEM_LATENCY+1 cycles.
- Read data registers: if_rdata and d_rdata each hold their last value until the next read to that port.
- Requests arriving during ACCESS are not sampled until the end of RESP.
- Counter width: 4 bits. MEM_LATENCY=1 gives exactly one ACCESS cycle.
- Reset asserted mid-access:
  - Next state IDLE; in-flight access dropped.
  - No rvalid is produced; mem_we is deasserted immediately.
- mem_sel in IDLE retains its last value (0 after reset).

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Port constants PORT_IF = 1'b0, PORT_D = 1'b1, matching the address-mux select encoding.
  - MEM_LATENCY legal-range constants.
- One sub-module is natural: mem_arb_pick, a combinational 2-way round-robin picker (inputs if_req, d_req, last_served; outputs valid and winner).
- FSM, counter and registers stay in mem_port_arbiter.

Test Plan:
1. Fetch only (MEM_LATENCY=2): after reset, if_req=1, if_addr=0x0000_0040 sampled at edge 0.
   -> if_gnt in cycle 1; mem_sel=0, mem_addr=0x40 in cycles 1-2; mem_rdata=0x8C01_0004 at cycle 2; if_rvalid=1, if_rdata=0x8C01_0004 in cycle 3; d_rvalid never pulses.
2. Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
   -> d_gnt and mem_we high for the first ACCESS cycle only; mem_sel=1; d_rvalid pulses in cycle 3; d_rdata unchanged.
3. Conflict from reset: if_req and d_req both held high.
   -> grants alternate IF, D, IF, D; a grant pulse every 3 cycles; busy stays 1 throughout.
4. Back-to-back loads: d_req re-asserted during RESP.
   -> the new d_gnt occurs the cycle after d_rvalid, with no idle cycle.
5. Reset mid-access: reset_n=0 in the second ACCESS cycle.
   -> next cycle all outputs 0, state IDLE, no rvalid; the next if_req wins (last_served reset to D).
6. MEM_LATENCY=1 build: single load.
   -> gnt in cycle 1, rvalid in cycle 2; sustained requests give one access per 2 cycles.
